// File: rtl/mcycle_sequencer.sv
// Issues MUL/DIV ops to the shared multi-cycle unit, stalls the front end while it runs and
// retires the buffered result through the shared write port. Optional timeout: MCSEQ_TIMEOUT_EN.
module mcycle_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mul_div_d_i,
  input  logic [1:0]       mcycle_op_d_i,
  input  logic [3:0]       rd_d_i,
  input  logic             busy_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             wb_ack_i,
  output logic             start_o,
  output logic [1:0]       mcycle_op_o,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             flush_e_o,
  output logic             reg_write_mc_o,
  output logic [3:0]       wa3_mc_o,
  output logic [WIDTH-1:0] wd3_mc_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             error_o
);

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StWb} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       rd_q, rd_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;
  logic             issue;

`ifdef MCSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MAX_CYCLES);
  logic err_q, err_d;
`endif

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rd_d           = rd_q;
    wd_d           = wd_q;
    cnt_d          = cnt_q;
    stall          = 1'b0;
    issue          = 1'b0;
    start_o        = 1'b0;
    reg_write_mc_o = 1'b0;
`ifdef MCSEQ_TIMEOUT_EN
    err_d          = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (mul_div_d_i) begin
          issue   = 1'b1;
          op_d    = mcycle_op_d_i;
          rd_d    = rd_d_i;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        stall   = 1'b1;
        start_o = 1'b1;
        if (busy_i) state_d = StBusy;
      end
      StBusy: begin
        stall = 1'b1;
`ifdef MCSEQ_TIMEOUT_EN
        if (busy_i && (cnt_q == TimeoutCnt)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else
`endif
        begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
          if (!busy_i) begin
            wd_d    = result_i;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        stall          = 1'b1;
        reg_write_mc_o = 1'b1;
        if (wb_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The issuing MUL/DIV must never reach Execute as an ALU op, hence the IDLE-cycle flush.
  assign stall_f_o     = stall;
  assign stall_d_o     = stall;
  assign flush_e_o     = stall | (issue & rst_ni);
  assign mcycle_op_o   = op_q;
  assign wa3_mc_o      = rd_q;
  assign wd3_mc_o      = wd_q;
  assign cycle_count_o = cnt_q;

`ifdef MCSEQ_TIMEOUT_EN
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= '0;
      rd_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
`ifdef MCSEQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
`ifdef MCSEQ_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed bench for mcycle_sequencer: per-cycle compare against a flag-based behavioural model,
// plus literal expectations on counts, captured data and the retired-write log.
module tb_mcycle_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] SatCnt = '1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mul_div;
  logic [1:0]       op_in;
  logic [3:0]       rd_in;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             wb_ack;
  logic             start_o;
  logic [1:0]       mcycle_op_o;
  logic             stall_f_o, stall_d_o, flush_e_o, reg_write_mc_o;
  logic [3:0]       wa3_mc_o;
  logic [WIDTH-1:0] wd3_mc_o;
  logic [CNT_W-1:0] cycle_count_o;
  logic             error_o;

  int errors = 0;
  int checks = 0;
  int start_hi = 0;
  logic [35:0] wlog[$];

  mcycle_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_CYCLES(40)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mul_div_d_i   (mul_div),
    .mcycle_op_d_i (op_in),
    .rd_d_i        (rd_in),
    .busy_i        (busy),
    .result_i      (result),
    .wb_ack_i      (wb_ack),
    .start_o       (start_o),
    .mcycle_op_o   (mcycle_op_o),
    .stall_f_o     (stall_f_o),
    .stall_d_o     (stall_d_o),
    .flush_e_o     (flush_e_o),
    .reg_write_mc_o(reg_write_mc_o),
    .wa3_mc_o      (wa3_mc_o),
    .wd3_mc_o      (wd3_mc_o),
    .cycle_count_o (cycle_count_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an op is either waiting for the unit, running, or holding a result.
  logic             m_issued, m_running, m_ready;
  logic [1:0]       m_op;
  logic [3:0]       m_rd;
  logic [WIDTH-1:0] m_wd;
  logic [CNT_W-1:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_issued <= 1'b0; m_running <= 1'b0; m_ready <= 1'b0;
      m_op <= '0; m_rd <= '0; m_wd <= '0; m_cnt <= '0;
    end else begin
      if (!m_issued && !m_running && !m_ready && mul_div) begin
        m_issued <= 1'b1; m_op <= op_in; m_rd <= rd_in; m_cnt <= '0;
      end
      if (m_issued && busy) begin
        m_issued <= 1'b0; m_running <= 1'b1;
      end
      if (m_running) begin
        m_cnt <= (m_cnt == SatCnt) ? SatCnt : m_cnt + 1'b1;
        if (!busy) begin
          m_running <= 1'b0; m_ready <= 1'b1; m_wd <= result;
        end
      end
      if (m_ready && wb_ack) m_ready <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic e_stall, e_idle;
    e_stall = m_issued | m_running | m_ready;
    e_idle  = !e_stall;
    chk("start", start_o, m_issued);
    chk("stall_f", stall_f_o, e_stall);
    chk("stall_d", stall_d_o, e_stall);
    chk("flush_e", flush_e_o, e_stall | (e_idle & mul_div & rst_n));
    chk("reg_write", reg_write_mc_o, m_ready);
    chk("mcycle_op", mcycle_op_o, m_op);
    chk("wa3", wa3_mc_o, m_rd);
    chk("wd3", wd3_mc_o, m_wd);
    chk("cycle_count", cycle_count_o, m_cnt);
    chk("error", error_o, 1'b0);
    if (start_o) start_hi++;
    if (rst_n && reg_write_mc_o && wb_ack) wlog.push_back({wa3_mc_o, wd3_mc_o});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] rd, input int sdel, input int blen,
                        input logic [31:0] res, input int ackd, input logic hold,
                        input logic [1:0] nop, input logic [3:0] nrd);
    mul_div = 1'b1; op_in = op; rd_in = rd;
    step();
    if (hold) begin
      op_in = nop; rd_in = nrd;
    end else begin
      mul_div = 1'b0;
    end
    busy = 1'b0;
    repeat (sdel) step();
    busy = 1'b1;
    repeat (blen) step();
    busy = 1'b0; result = res;
    step();
    result = 32'hDEAD_BEEF; wb_ack = 1'b0;
    repeat (ackd) step();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
  endtask

  initial begin
    logic [35:0] exp_log[6];
    int n_exp;
    rst_n = 1'b0; mul_div = 1'b0; op_in = '0; rd_in = '0; busy = 1'b0;
    result = 32'hDEAD_BEEF; wb_ack = 1'b0;
    repeat (3) step();
    chk("rst_start", start_o, 1'b0);
    chk("rst_wa3", wa3_mc_o, 4'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // MUL 25*8 into r5; Busy high 33 cycles.
    start_hi = 0;
    run_op(2'b00, 4'd5, 0, 33, 32'h0000_00C8, 0, 1'b0, 2'b00, 4'd0);
    chk("mul_count", cycle_count_o, 6'd33);
    chk("mul_wa3", wa3_mc_o, 4'd5);
    chk("mul_wd3", wd3_mc_o, 32'h0000_00C8);
    chk("mul_start_cycles", start_hi, 1);
    step();

    // DIV 56/8 into r3 with three cycles of withheld ack.
    run_op(2'b10, 4'd3, 1, 10, 32'h0000_0007, 3, 1'b0, 2'b00, 4'd0);
    chk("div_count", cycle_count_o, 6'd10);
    chk("div_wd3", wd3_mc_o, 32'h0000_0007);
    chk("div_op", mcycle_op_o, 2'b10);
    step();

    // Unit raises Busy late; Start must cover every waiting cycle plus the Busy-seen cycle.
    start_hi = 0;
    run_op(2'b01, 4'd9, 3, 5, 32'h1234_5678, 0, 1'b0, 2'b00, 4'd0);
    chk("late_start_cycles", start_hi, 4);
    chk("late_count", cycle_count_o, 6'd5);
    step();

    // Back-to-back: next MUL/DIV waits in Decode during the first op.
    run_op(2'b11, 4'd4, 0, 6, 32'hFFFF_FFF0, 1, 1'b1, 2'b01, 4'd6);
    chk("b2b_flush", flush_e_o, 1'b1);
    chk("b2b_stall", stall_f_o, 1'b0);
    chk("b2b_wa3_first", wa3_mc_o, 4'd4);
    run_op(2'b01, 4'd6, 0, 4, 32'h0000_00F0, 0, 1'b0, 2'b00, 4'd0);
    chk("b2b_wa3_second", wa3_mc_o, 4'd6);
    chk("b2b_wd3_second", wd3_mc_o, 32'h0000_00F0);
    step();

    n_exp = 5;
`ifndef MCSEQ_TIMEOUT_EN
    // Counter saturates at all-ones on a very long op.
    run_op(2'b00, 4'd2, 0, 70, 32'hA5A5_0001, 0, 1'b0, 2'b00, 4'd0);
    chk("sat_count", cycle_count_o, SatCnt);
    n_exp = 6;
    step();
`endif

    // Reset in the middle of BUSY abandons the op.
    mul_div = 1'b1; op_in = 2'b00; rd_in = 4'd7;
    step();
    mul_div = 1'b0; busy = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", stall_f_o, 1'b0);
    chk("midrst_flush", flush_e_o, 1'b0);
    chk("midrst_regwr", reg_write_mc_o, 1'b0);
    chk("midrst_count", cycle_count_o, 6'd0);
    chk("midrst_wd3", wd3_mc_o, 32'd0);
    step();
    rst_n = 1'b1; busy = 1'b0;
    repeat (4) step();
    chk("postrst_stall", stall_d_o, 1'b0);

    exp_log[0] = {4'd5, 32'h0000_00C8};
    exp_log[1] = {4'd3, 32'h0000_0007};
    exp_log[2] = {4'd9, 32'h1234_5678};
    exp_log[3] = {4'd4, 32'hFFFF_FFF0};
    exp_log[4] = {4'd6, 32'h0000_00F0};
    exp_log[5] = {4'd2, 32'hA5A5_0001};
    chk("write_count", wlog.size(), n_exp);
    for (int i = 0; i < n_exp && i < wlog.size(); i++) chk("write_log", wlog[i], exp_log[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
